seq_alu: RTL

- Parametrised, handshaked successor to the integer ALU.
- Single-cycle ops (add/sub/shift/compare/logic, RV64 W-forms) are registered with 1-cycle latency.
- Zbc carry-less multiplies (clmul/clmulh/clmulr) run on an iterative engine processing BPC bits of B per cycle.
- Sits in the execute stage as a stallable functional unit alongside the divider, with a one-entry output register.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_clmul_step.sv | 29 ++
 rtl/seq_alu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu package (cvw): opcode encoding, FSM state type and the clmul opcode set.
// Shared by seq_alu, clmul_step and the bench.
package cvw;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SRL    = 4'd3,
    ALU_SRA    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_XOR    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_CLMUL  = 4'd10,
    ALU_CLMULH = 4'd11,
    ALU_CLMULR = 4'd12
  } aluop_t;

  typedef enum logic {S_IDLE, S_ITER} alu_state_t;

  // Opcodes that go to the iterative engine; everything else completes in one cycle.
  localparam logic [3:0] CLMUL_OPS [3] = '{4'd10, 4'd11, 4'd12};

  function automatic logic is_clmul(input logic [3:0] op);
    is_clmul = 1'b0;
    foreach (CLMUL_OPS[i])
      if (op == CLMUL_OPS[i]) is_clmul = 1'b1;
  endfunction

endpackage

// File: rtl/seq_alu_clmul_step.sv
// clmul_step: one iteration of the carry-less multiply engine (combinational).
// Ports:
//   a       - latched operand A
//   bslice  - BPC-bit slice of B for this iteration
//   acc     - current 2*WIDTH accumulator
//   idx     - iteration index (slice number)
//   acc_nxt - accumulator after XORing in A << (idx*BPC + j) for each set bit j
module clmul_step #(
  parameter int WIDTH = 64,
  parameter int BPC   = 4,
  parameter int CNTW  = $clog2(WIDTH/BPC)+1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [BPC-1:0]     bslice,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [CNTW-1:0]    idx,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [2*WIDTH-1:0] base;

  always_comb begin
    base    = {{WIDTH{1'b0}}, a} << (int'(idx) * BPC);
    acc_nxt = acc;
    for (int j = 0; j < BPC; j++)
      if (bslice[j]) acc_nxt = acc_nxt ^ (base << j);
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked execute-stage ALU with a one-entry output register.
// Single-cycle ops (add/sub/shifts/compares/logic, W-forms) land in the output
// register on the accept edge; clmul/clmulh/clmulr iterate BPC bits of B per cycle.
// Ports:
//   clk, reset_n         - clock, async active-low reset
//   InValid/InReady      - request handshake (A, B, Op, W64)
//   Flush                - kill in-flight op and pending output
//   OutValid/OutReady    - result handshake (Result)
//   Busy                 - iterative engine active
// Build option: SEQ_ALU_EARLY_OUT_EN ends clmul as soon as the remaining B bits are zero.
module seq_alu import cvw::*; #(
  parameter int WIDTH = 64,
  parameter int BPC   = 4,
  parameter int CNTW  = $clog2(WIDTH/BPC)+1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  input  logic             W64,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Busy
);

  localparam int K   = WIDTH / BPC;
  localparam int SHW = $clog2(WIDTH);

  alu_state_t         state;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [BPC-1:0]     slice;
  logic               accept, last, w;
  logic [SHW-1:0]     shamt;
  logic [31:0]        a32, b32, r32;
  logic [WIDTH-1:0]   rfull, alu_res, clmul_res;

  assign InReady = (state == S_IDLE) & (~OutValid | OutReady) & ~Flush;
  assign accept  = InValid & InReady;
  assign Busy    = (state == S_ITER);

  // ---------------- single-cycle datapath ----------------
  assign w = (WIDTH == 64) && W64;

  always_comb begin
    shamt = B[SHW-1:0];
    if (w) shamt = SHW'(B[4:0]);
  end

  // Both the full-width and the 32-bit result are formed; W64 picks the
  // 32-bit one and sign-extends its bit 31.
  always_comb begin
    a32   = A[31:0];
    b32   = B[31:0];
    rfull = '0;
    r32   = '0;
    case (Op)
      ALU_ADD:  begin rfull = A + B;   r32 = a32 + b32; end
      ALU_SUB:  begin rfull = A - B;   r32 = a32 - b32; end
      ALU_SLL:  begin rfull = A << shamt;  r32 = a32 << B[4:0]; end
      ALU_SRL:  begin rfull = A >> shamt;  r32 = a32 >> B[4:0]; end
      ALU_SRA:  begin rfull = $signed(A) >>> shamt; r32 = $signed(a32) >>> B[4:0]; end
      ALU_SLT:  begin
        rfull = WIDTH'($signed(A) < $signed(B));
        r32   = 32'($signed(a32) < $signed(b32));
      end
      ALU_SLTU: begin rfull = WIDTH'(A < B); r32 = 32'(a32 < b32); end
      ALU_XOR:  begin rfull = A ^ B;   r32 = a32 ^ b32; end
      ALU_OR:   begin rfull = A | B;   r32 = a32 | b32; end
      ALU_AND:  begin rfull = A & B;   r32 = a32 & b32; end
      default:  begin rfull = '0;      r32 = '0; end
    endcase
    alu_res = w ? WIDTH'($signed(r32)) : rfull;
  end

  // ---------------- clmul engine ----------------
  assign slice = b_q[int'(cnt)*BPC +: BPC];

  clmul_step #(.WIDTH(WIDTH), .BPC(BPC), .CNTW(CNTW)) u_step (
    .a      (a_q),
    .bslice (slice),
    .acc    (acc),
    .idx    (cnt),
    .acc_nxt(acc_nxt)
  );

`ifdef SEQ_ALU_EARLY_OUT_EN
  // Stop once every B bit above the slice just consumed is zero.
  assign last = (cnt == CNTW'(K-1)) || ((b_q >> ((int'(cnt)+1)*BPC)) == '0);
`else
  assign last = (cnt == CNTW'(K-1));
`endif

  always_comb begin
    case (op_q)
      ALU_CLMULH: clmul_res = acc_nxt[2*WIDTH-1:WIDTH];
      ALU_CLMULR: clmul_res = acc_nxt[2*WIDTH-2:WIDTH-1];
      default:    clmul_res = acc_nxt[WIDTH-1:0];
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      OutValid <= 1'b0;
      Result   <= '0;
      cnt      <= '0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else if (Flush) begin
      state    <= S_IDLE;
      OutValid <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      // Drain first; a result written below in the same cycle takes precedence.
      if (OutValid && OutReady) OutValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_clmul(Op)) begin
              state <= S_ITER;
              a_q   <= A;
              b_q   <= B;
              op_q  <= Op;
              cnt   <= '0;
              acc   <= '0;
            end else begin
              Result   <= alu_res;
              OutValid <= 1'b1;
            end
          end
        end
        S_ITER: begin
          acc <= acc_nxt;
          cnt <= cnt + CNTW'(1);
          if (last) begin
            state    <= S_IDLE;
            Result   <= clmul_res;
            OutValid <= 1'b1;
            cnt      <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
